// File: rtl/exec_pkg.sv
// Shared opcode constants, instruction field positions and FSM encodings for exec_unit.
package exec_pkg;

  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 16;
  localparam int OPA_MSB = 15;
  localparam int OPA_LSB = 8;
  localparam int OPB_MSB = 7;
  localparam int OPB_LSB = 0;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_AND = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_JZ  = 8'h07;
  localparam logic [7:0] OP_JC  = 8'h08;
  localparam logic [7:0] OP_MUL = 8'h09;

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2,
    ST_MUL  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for ADD/SUB/AND/OR; carry is carry-out for ADD and borrow for SUB, zero otherwise.
module exec_alu
  import exec_pkg::*;
(
  input  logic [7:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_result,
  output logic       o_carry,
  output logic       o_zero
);

  logic [8:0] w_wide;

  always_comb begin
    w_wide = 9'h000;
    case (i_op)
      OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
      OP_AND:  w_wide = {1'b0, i_a & i_b};
      OP_OR:   w_wide = {1'b0, i_a | i_b};
      default: w_wide = 9'h000;
    endcase
  end

  assign o_result = w_wide[7:0];
  assign o_carry  = w_wide[8];
  assign o_zero   = (w_wide[7:0] == 8'h00);

endmodule

// File: rtl/exec_unit.sv
// Single-issue executor: op_done/pc_br_en two cycles after acceptance (MUL adds 8 with EXEC_MUL_EN).
// No backpressure: op_rdy while busy is dropped and flagged in sticky overrun.
module exec_unit
  import exec_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_op_rdy,
  input  logic [23:0] i_full_opcode,
  input  logic [1:0]  i_dbg_sel,
  output logic        o_busy,
  output logic        o_op_done,
  output logic        o_pc_br_en,
  output logic [7:0]  o_pc_next_instr_addr,
  output logic        o_flag_z,
  output logic        o_flag_c,
  output logic        o_illegal,
  output logic        o_overrun,
  output logic [7:0]  o_dbg_data
);

  state_t      r_state;
  state_t      w_next_state;
  logic [23:0] r_instr;
  logic [7:0]  r_regs [NUM_REGS];
  logic        r_flag_z;
  logic        r_flag_c;
  logic        r_illegal;
  logic        r_overrun;
  logic        r_pc_br_en;
  logic [7:0]  r_pc_addr;

  logic [7:0]  w_opc;
  logic [1:0]  w_ra;
  logic [1:0]  w_rb;
  logic [7:0]  w_imm;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [7:0]  w_alu_res;
  logic        w_alu_c;
  logic        w_alu_z;
  logic        w_take;
  logic        w_unused_a;

  assign w_opc      = r_instr[OPC_MSB:OPC_LSB];
  assign w_ra       = r_instr[OPA_LSB+1:OPA_LSB];
  assign w_rb       = r_instr[OPB_LSB+1:OPB_LSB];
  assign w_imm      = r_instr[OPB_MSB:OPB_LSB];
  assign w_unused_a = ^r_instr[OPA_MSB:OPA_LSB+2];
  assign w_a        = r_regs[w_ra];
  assign w_b        = r_regs[w_rb];

  exec_alu u_alu (
    .i_op     (w_opc),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_alu_res),
    .o_carry  (w_alu_c),
    .o_zero   (w_alu_z)
  );

  // Conditional jumps test the flags as they stood before this instruction.
  always_comb begin
    w_take = 1'b0;
    case (w_opc)
      OP_JMP:  w_take = 1'b1;
      OP_JZ:   w_take = r_flag_z;
      OP_JC:   w_take = r_flag_c;
      default: w_take = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic [15:0] r_mul_acc;
  logic [15:0] r_mul_mcand;
  logic [7:0]  r_mul_mplier;
  logic [2:0]  r_mul_cnt;
  logic [15:0] w_mul_sum;
  logic        w_mul_last;

  assign w_mul_sum  = r_mul_acc + (r_mul_mplier[0] ? r_mul_mcand : 16'h0000);
  assign w_mul_last = (r_mul_cnt == 3'd7);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_op_done    = 1'b0;
    case (r_state)
      ST_IDLE: if (i_op_rdy) w_next_state = ST_EXEC;
`ifdef EXEC_MUL_EN
      ST_EXEC: w_next_state = (w_opc == OP_MUL) ? ST_MUL : ST_DONE;
      ST_MUL:  if (w_mul_last) w_next_state = ST_DONE;
`else
      ST_EXEC: w_next_state = ST_DONE;
`endif
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    o_busy    = (r_state != ST_IDLE);
    o_op_done = (r_state == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      r_instr    <= 24'h000000;
      r_flag_z   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_illegal  <= 1'b0;
      r_overrun  <= 1'b0;
      r_pc_br_en <= 1'b0;
      r_pc_addr  <= 8'h00;
`ifdef EXEC_MUL_EN
      r_mul_acc    <= 16'h0000;
      r_mul_mcand  <= 16'h0000;
      r_mul_mplier <= 8'h00;
      r_mul_cnt    <= 3'd0;
`endif
    end else begin
      r_pc_br_en <= 1'b0;
      if (i_op_rdy) begin
        if (r_state == ST_IDLE) r_instr   <= i_full_opcode;
        else                    r_overrun <= 1'b1;
      end
      if (r_state == ST_EXEC) begin
        case (w_opc)
          OP_NOP: ;
          OP_LDI: r_regs[w_ra] <= w_imm;
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            r_regs[w_ra] <= w_alu_res;
            r_flag_z     <= w_alu_z;
            r_flag_c     <= w_alu_c;
          end
          OP_JMP, OP_JZ, OP_JC: begin
            if (w_take) begin
              r_pc_br_en <= 1'b1;
              r_pc_addr  <= w_imm;
            end
          end
`ifdef EXEC_MUL_EN
          OP_MUL: begin
            r_mul_acc    <= 16'h0000;
            r_mul_mcand  <= {8'h00, w_a};
            r_mul_mplier <= w_b;
            r_mul_cnt    <= 3'd0;
          end
`endif
          default: r_illegal <= 1'b1;
        endcase
      end
`ifdef EXEC_MUL_EN
      // One multiplier bit per cycle; the eighth step also retires the result.
      if (r_state == ST_MUL) begin
        r_mul_acc    <= w_mul_sum;
        r_mul_mcand  <= {r_mul_mcand[14:0], 1'b0};
        r_mul_mplier <= {1'b0, r_mul_mplier[7:1]};
        r_mul_cnt    <= r_mul_cnt + 3'd1;
        if (w_mul_last) begin
          r_regs[w_ra] <= w_mul_sum[7:0];
          r_flag_c     <= |w_mul_sum[15:8];
          r_flag_z     <= (w_mul_sum[7:0] == 8'h00);
        end
      end
`endif
    end
  end

  assign o_pc_br_en           = r_pc_br_en;
  assign o_pc_next_instr_addr = r_pc_addr;
  assign o_flag_z             = r_flag_z;
  assign o_flag_c             = r_flag_c;
  assign o_illegal            = r_illegal;
  assign o_overrun            = r_overrun;
  assign o_dbg_data           = r_regs[i_dbg_sel];

endmodule

// File: tb/tb_exec_unit.sv
// Directed vector table plus hand sequences for overrun, reset abort and opcode 09.
module tb_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        op_rdy;
  logic [23:0] full_opcode;
  logic [1:0]  dbg_sel;
  logic        busy;
  logic        op_done;
  logic        pc_br_en;
  logic [7:0]  pc_addr;
  logic        flag_z;
  logic        flag_c;
  logic        illegal;
  logic        overrun;
  logic [7:0]  dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  exec_unit dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_op_rdy             (op_rdy),
    .i_full_opcode        (full_opcode),
    .i_dbg_sel            (dbg_sel),
    .o_busy               (busy),
    .o_op_done            (op_done),
    .o_pc_br_en           (pc_br_en),
    .o_pc_next_instr_addr (pc_addr),
    .o_flag_z             (flag_z),
    .o_flag_c             (flag_c),
    .o_illegal            (illegal),
    .o_overrun            (overrun),
    .o_dbg_data           (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] instr;
    logic [1:0]  sel;
    logic [7:0]  dbg;
    logic        z;
    logic        c;
    logic        br;
    logic [7:0]  addr;
    logic        ill;
  } vec_t;

  vec_t vecs [20];

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // Returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [23:0] instr);
    @(negedge clk);
    op_rdy      = 1'b1;
    full_opcode = instr;
    @(negedge clk);
    op_rdy      = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    send(v.instr);
    chk1($sformatf("v%0d busy_acc", idx), busy, 1'b1);
    chk1($sformatf("v%0d done_early", idx), op_done, 1'b0);
    @(negedge clk);
    chk1($sformatf("v%0d done", idx), op_done, 1'b1);
    chk1($sformatf("v%0d busy_done", idx), busy, 1'b1);
    chk1($sformatf("v%0d br", idx), pc_br_en, v.br);
    if (v.br) chk8($sformatf("v%0d br_addr", idx), pc_addr, v.addr);
    @(negedge clk);
    chk1($sformatf("v%0d done_clr", idx), op_done, 1'b0);
    chk1($sformatf("v%0d busy_clr", idx), busy, 1'b0);
    chk1($sformatf("v%0d br_clr", idx), pc_br_en, 1'b0);
    dbg_sel = v.sel;
    #1;
    chk8($sformatf("v%0d dbg", idx), dbg_data, v.dbg);
    chk1($sformatf("v%0d z", idx), flag_z, v.z);
    chk1($sformatf("v%0d c", idx), flag_c, v.c);
    chk1($sformatf("v%0d ill", idx), illegal, v.ill);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    int lat;

    //          instr       sel   dbg    z     c     br    addr   ill
    vecs[0]  = '{24'h010105, 2'd1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{24'h0102FB, 2'd2, 8'hFB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{24'h020102, 2'd1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{24'h070040, 2'd1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0};
    vecs[4]  = '{24'h030201, 2'd2, 8'hFB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{24'h070010, 2'd2, 8'hFB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{24'h080020, 2'd2, 8'hFB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{24'h01FF80, 2'd3, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{24'h0247F7, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{24'h080033, 2'd3, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0};
    vecs[10] = '{24'h01000F, 2'd0, 8'h0F, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{24'h01013C, 2'd1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{24'h040001, 2'd0, 8'h0C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{24'h050100, 2'd1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{24'h030001, 2'd0, 8'hD0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{24'h040203, 2'd2, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[16] = '{24'h060099, 2'd2, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0};
    vecs[17] = '{24'h000000, 2'd0, 8'hD0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[18] = '{24'hFF0102, 2'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[19] = '{24'h030101, 2'd1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};

    rst_n       = 1'b1;
    op_rdy      = 1'b0;
    full_opcode = 24'h000000;
    dbg_sel     = 2'd0;
    #2 rst_n = 1'b0;
    #2;
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", op_done, 1'b0);
    chk1("rst br", pc_br_en, 1'b0);
    chk8("rst addr", pc_addr, 8'h00);
    chk1("rst z", flag_z, 1'b0);
    chk1("rst c", flag_c, 1'b0);
    chk1("rst ill", illegal, 1'b0);
    chk1("rst ovr", overrun, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0];
      #1 chk8($sformatf("rst r%0d", i), dbg_data, 8'h00);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Back-to-back op_rdy: the second is dropped.
    chk1("ovr pre", overrun, 1'b0);
    send(24'h010211);
    op_rdy      = 1'b1;
    full_opcode = 24'h010222;
    @(negedge clk);
    op_rdy = 1'b0;
    dones  = 0;
    for (int i = 0; i < 6; i++) begin
      if (op_done) dones++;
      @(negedge clk);
    end
    chk8("ovr done_count", dones[7:0], 8'd1);
    chk1("ovr flag", overrun, 1'b1);
    dbg_sel = 2'd2;
    #1 chk8("ovr r2", dbg_data, 8'h11);

    // Reset while ADD r0,r0 sits in EXEC; op_rdy held across release.
    send(24'h020000);
    #1 rst_n = 1'b0;
    op_rdy      = 1'b1;
    full_opcode = 24'h010077;
    dbg_sel     = 2'd0;
    #1;
    chk1("abort busy", busy, 1'b0);
    chk1("abort done", op_done, 1'b0);
    chk1("abort br", pc_br_en, 1'b0);
    chk8("abort addr", pc_addr, 8'h00);
    chk1("abort z", flag_z, 1'b0);
    chk1("abort c", flag_c, 1'b0);
    chk1("abort ill", illegal, 1'b0);
    chk1("abort ovr", overrun, 1'b0);
    chk8("abort r0", dbg_data, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1($sformatf("abort hold_done%0d", i), op_done, 1'b0);
      chk1($sformatf("abort hold_busy%0d", i), busy, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    op_rdy = 1'b0;
    chk1("post busy", busy, 1'b1);
    chk1("post done_early", op_done, 1'b0);
    @(negedge clk);
    chk1("post done", op_done, 1'b1);
    @(negedge clk);
    chk1("post done_clr", op_done, 1'b0);
    #1;
    chk8("post r0", dbg_data, 8'h77);
    chk1("post ovr", overrun, 1'b0);

    run_vec('{24'h010010, 2'd0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}, 100);
    run_vec('{24'h010120, 2'd1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}, 101);
`ifdef EXEC_MUL_EN
    send(24'h090001);
    lat = 21;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (op_done) begin
        lat = k;
        break;
      end
    end
    chk8("mul latency", lat[7:0], 8'd9);
    @(negedge clk);
    dbg_sel = 2'd0;
    #1;
    chk8("mul r0", dbg_data, 8'h00);
    chk1("mul c", flag_c, 1'b1);
    chk1("mul z", flag_z, 1'b1);
    chk1("mul ill", illegal, 1'b0);
`else
    lat = 0;
    run_vec('{24'h090001, 2'd0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1}, 102);
    chk8("op09 lat_unused", lat[7:0], 8'd0 + {7'd0, busy});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: NUM_REGS, 4, number of 8-bit general registers r0..r3 (fixed at 4; index is 2 bits).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 op_rdy  input  1  one-cycle strobe from instruction register: full_opcode valid.
REQ-005 full_opcode  input  24  [23:16] opcode, [15:8] operand A, [7:0] operand B.
REQ-006 busy  output  1  high from the cycle after acceptance until op_done inclusive.
REQ-007 op_done  output  1  one-cycle pulse: instruction retired.
REQ-008 pc_br_en  output  1  one-cycle branch-taken pulse to program counter.
REQ-009 pc_next_instr_addr  output  8  branch target; valid while pc_br_en high.
REQ-010 flag_z, flag_c  output  1 each  zero and carry flags.
REQ-011 illegal  output  1  sticky: undefined opcode retired.
REQ-012 overrun  output  1  sticky: op_rdy seen while busy.
REQ-013 dbg_sel  input  2 / dbg_data  output  8  combinational register read port.

Function
REQ-014 Opcode map: 00 NOP; 01 LDI r[A[1:0]]<=B; 02 ADD r[A]<=r[A]+r[B]; 03 SUB r[A]<=r[A]-r[B]; 04 AND; 05 OR; 06 JMP B; 07 JZ B; 08 JC B; all others illegal.
REQ-015 FSM states IDLE, EXEC, DONE (plus MUL when enabled); IDLE->EXEC on op_rdy, EXEC->DONE, DONE->IDLE unconditionally.
REQ-016 op_rdy sampled in IDLE at edge N latches full_opcode; register write and flag update at edge N+1; op_done and pc_br_en high during cycle after N+1 (latency 2).
REQ-017 op_rdy while busy is dropped, instruction not latched, overrun set.
REQ-018 ADD/SUB 8-bit wrap; flag_c = carry out (ADD) or borrow (SUB); flag_z = result==0.
REQ-019 AND/OR: flag_z updated, flag_c cleared; LDI, NOP, jumps leave flags unchanged.
REQ-020 Jumps: pc_br_en asserted only if taken (JMP always, JZ if flag_z, JC if flag_c), using flags before this instruction.
REQ-021 Register operand index uses low 2 bits of A/B; upper bits ignored.
REQ-022 Illegal opcode: no register/flag change, illegal set, op_done still pulses.
REQ-023 dbg_data = r[dbg_sel] combinationally, reflecting writes from the next cycle after the write edge.

Reset
REQ-024 rst low: FSM to IDLE; r0..r3, flags, illegal, overrun, pc_next_instr_addr to 0; busy, op_done, pc_br_en low, asynchronously.
REQ-025 rst asserted mid-instruction aborts it: no op_done, no pc_br_en, no register write after release.
REQ-026 First op_rdy accepted is the one sampled at the first rising edge with rst high.

Configuration
REQ-027 Macro EXEC_MUL_EN defined: opcode 09 MUL r[A]<=low8(r[A]*r[B]) via 8-cycle shift-add in state MUL; flag_c = high byte nonzero; flag_z = low8==0; op_done at N+10.
REQ-028 EXEC_MUL_EN undefined: opcode 09 is illegal per REQ-022; no MUL state or multiplier logic.

Structure
REQ-029 Package exec_pkg holds opcode constants, FSM state encodings, field slice positions.
REQ-030 Sub-module exec_alu: combinational ADD/SUB/AND/OR with result, carry, zero; registers and FSM stay in exec_unit.

Verification
REQ-031 LDI r1,0x05; LDI r2,0xFB; ADD r1,r2 -> r1=0x00, flag_z=1, flag_c=1, op_done 2 cycles after each op_rdy.
REQ-032 After REQ-031, JZ 0x40 -> pc_br_en one cycle, pc_next_instr_addr=0x40; then SUB r2=0xFB-r1 (0) -> JZ 0x10 gives no pc_br_en.
REQ-033 op_rdy on cycle after acceptance -> second instruction ignored, overrun=1, only one op_done.
REQ-034 Opcode 0xFF -> illegal=1, registers unchanged, op_done pulses.
REQ-035 rst low in EXEC of ADD -> all outputs zero, no op_done; next LDI after release executes normally.
REQ-036 With EXEC_MUL_EN: r0=0x10, r1=0x20, MUL r0,r1 -> r0=0x00, flag_c=1, flag_z=1, op_done at N+10; without macro -> illegal=1.
